// File: rtl/wb_stage_if.sv
// Writeback-stage bus: MEM-stage entry, divider handshake, register-file write port and retire count.
`default_nettype none

interface wb_stage_if #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int INSTRET_W  = 64
);
   logic                  flush_i;
   logic                  mem_valid_i;
   logic                  mem_wen_i;
   logic [REG_ADDR_W-1:0] mem_rd_i;
   logic [XLEN-1:0]       mem_result_i;
   logic                  mem_is_load_i;
   logic [2:0]            mem_funct3_i;
   logic [XLEN-1:0]       mem_rdata_i;
   logic                  wb_stall_o;
   logic                  div_valid_i;
   logic [REG_ADDR_W-1:0] div_rd_i;
   logic [XLEN-1:0]       div_result_i;
   logic                  div_ready_o;
   logic                  reg_wen_o;
   logic [REG_ADDR_W-1:0] reg_waddr_o;
   logic [XLEN-1:0]       reg_wdata_o;
   logic [INSTRET_W-1:0]  instret_o;

   modport master (
      output flush_i, mem_valid_i, mem_wen_i, mem_rd_i, mem_result_i, mem_is_load_i,
             mem_funct3_i, mem_rdata_i, div_valid_i, div_rd_i, div_result_i,
      input  wb_stall_o, div_ready_o, reg_wen_o, reg_waddr_o, reg_wdata_o, instret_o
   );

   modport slave (
      input  flush_i, mem_valid_i, mem_wen_i, mem_rd_i, mem_result_i, mem_is_load_i,
             mem_funct3_i, mem_rdata_i, div_valid_i, div_rd_i, div_result_i,
      output wb_stall_o, div_ready_o, reg_wen_o, reg_waddr_o, reg_wdata_o, instret_o
   );
endinterface

`default_nettype wire

// File: rtl/wb_stage.sv
// Writeback stage: registers MEM results (with load formatting), merges divider results
// through a one-entry buffer, and counts retired instructions.
`default_nettype none

module wb_stage #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int INSTRET_W  = 64
) (
   input  wire          clk_i,
   input  wire          rst_n_i,
   wb_stage_if.slave    bus
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] PEND = 1'b1;

   logic [0:0]            state_q, state_d;
   logic                  buf_valid_q, buf_valid_d;
   logic [REG_ADDR_W-1:0] buf_rd_q, buf_rd_d;
   logic [XLEN-1:0]       buf_data_q, buf_data_d;
   logic                  reg_wen_q, reg_wen_d;
   logic [REG_ADDR_W-1:0] reg_waddr_q, reg_waddr_d;
   logic [XLEN-1:0]       reg_wdata_q, reg_wdata_d;
   logic [INSTRET_W-1:0]  instret_q, instret_d;

   logic                  is_idle;
   logic                  mem_cap;
   logic                  div_acc;
   logic [1:0]            off;
   logic [7:0]            ld_byte;
   logic [15:0]           ld_half;
   logic [XLEN-1:0]       mem_data;

   assign is_idle = (state_q == IDLE);
   assign mem_cap = bus.mem_valid_i & ~bus.flush_i & is_idle;
   assign div_acc = bus.div_valid_i & is_idle;
   assign off     = bus.mem_result_i[1:0];

   always_comb begin
      ld_byte = 8'h00;
      case (off)
         2'd0:    ld_byte = bus.mem_rdata_i[7:0];
         2'd1:    ld_byte = bus.mem_rdata_i[15:8];
         2'd2:    ld_byte = bus.mem_rdata_i[23:16];
         default: ld_byte = bus.mem_rdata_i[31:24];
      endcase
      ld_half = off[1] ? bus.mem_rdata_i[31:16] : bus.mem_rdata_i[15:0];

      mem_data = bus.mem_result_i;
      if (bus.mem_is_load_i) begin
         case (bus.mem_funct3_i)
            3'd0:    mem_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'd1:    mem_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'd2:    mem_data = bus.mem_rdata_i;
            3'd4:    mem_data = {{(XLEN-8){1'b0}}, ld_byte};
            3'd5:    mem_data = {{(XLEN-16){1'b0}}, ld_half};
            default: mem_data = '0;
         endcase
      end
   end

   always_comb begin
      state_d     = state_q;
      buf_valid_d = buf_valid_q;
      buf_rd_d    = buf_rd_q;
      buf_data_d  = buf_data_q;
      reg_wen_d   = 1'b0;
      reg_waddr_d = reg_waddr_q;
      reg_wdata_d = reg_wdata_q;
      instret_d   = instret_q;

      if (state_q == IDLE) begin
         if (mem_cap) begin
            reg_wen_d   = bus.mem_wen_i & (bus.mem_rd_i != '0);
            reg_waddr_d = bus.mem_rd_i;
            reg_wdata_d = mem_data;
            instret_d   = instret_q + INSTRET_W'(1);
            // MEM owns the write port this cycle, so a concurrent divider result waits one cycle
            if (div_acc) begin
               buf_valid_d = 1'b1;
               buf_rd_d    = bus.div_rd_i;
               buf_data_d  = bus.div_result_i;
               state_d     = PEND;
            end
         end else if (div_acc) begin
            reg_wen_d   = (bus.div_rd_i != '0);
            reg_waddr_d = bus.div_rd_i;
            reg_wdata_d = bus.div_result_i;
         end
      end else begin
         reg_wen_d   = buf_valid_q & (buf_rd_q != '0);
         reg_waddr_d = buf_rd_q;
         reg_wdata_d = buf_data_q;
         buf_valid_d = 1'b0;
         state_d     = IDLE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q     <= IDLE;
         buf_valid_q <= 1'b0;
         buf_rd_q    <= '0;
         buf_data_q  <= '0;
         reg_wen_q   <= 1'b0;
         reg_waddr_q <= '0;
         reg_wdata_q <= '0;
         instret_q   <= '0;
      end else begin
         state_q     <= state_d;
         buf_valid_q <= buf_valid_d;
         buf_rd_q    <= buf_rd_d;
         buf_data_q  <= buf_data_d;
         reg_wen_q   <= reg_wen_d;
         reg_waddr_q <= reg_waddr_d;
         reg_wdata_q <= reg_wdata_d;
         instret_q   <= instret_d;
      end
   end

   assign bus.wb_stall_o  = (state_q == PEND);
   assign bus.div_ready_o = (state_q == IDLE);
   assign bus.reg_wen_o   = reg_wen_q;
   assign bus.reg_waddr_o = reg_waddr_q;
   assign bus.reg_wdata_o = reg_wdata_q;
   assign bus.instret_o   = instret_q;
endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage: load formatting, retire counting, divider merge and reset.
`default_nettype none

module tb_wb_stage;
   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;
   logic [63:0] exp_instret;

   wb_stage_if #(.XLEN(32), .REG_ADDR_W(5), .INSTRET_W(64)) bus ();

   wb_stage #(.XLEN(32), .REG_ADDR_W(5), .INSTRET_W(64)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.flush_i       = 1'b0;
      bus.mem_valid_i   = 1'b0;
      bus.mem_wen_i     = 1'b0;
      bus.mem_rd_i      = 5'd0;
      bus.mem_result_i  = 32'h0;
      bus.mem_is_load_i = 1'b0;
      bus.mem_funct3_i  = 3'd0;
      bus.mem_rdata_i   = 32'h0;
      bus.div_valid_i   = 1'b0;
      bus.div_rd_i      = 5'd0;
      bus.div_result_i  = 32'h0;
   endtask

   task automatic drive_mem(input logic is_load, input logic [2:0] f3, input logic [4:0] rd,
                            input logic [31:0] result, input logic [31:0] rdata);
      bus.mem_valid_i   = 1'b1;
      bus.mem_wen_i     = 1'b1;
      bus.mem_rd_i      = rd;
      bus.mem_result_i  = result;
      bus.mem_is_load_i = is_load;
      bus.mem_funct3_i  = f3;
      bus.mem_rdata_i   = rdata;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      exp_instret = 64'd0;
      n_vec++;
      if (bus.reg_wen_o !== 1'b0 || bus.reg_waddr_o !== 5'd0 || bus.reg_wdata_o !== 32'h0) begin
         n_err++;
         $display("FAIL reset_regs: got wen=%b waddr=%0d wdata=%h, want 0/0/0",
                  bus.reg_wen_o, bus.reg_waddr_o, bus.reg_wdata_o);
      end
      n_vec++;
      if (bus.instret_o !== 64'd0 || bus.wb_stall_o !== 1'b0 || bus.div_ready_o !== 1'b1) begin
         n_err++;
         $display("FAIL reset_state: got instret=%0d stall=%b ready=%b, want 0/0/1",
                  bus.instret_o, bus.wb_stall_o, bus.div_ready_o);
      end
   endtask

   task automatic test_load_format();
      // {funct3, rd, result, rdata, expected wdata}
      logic [2:0]  f3 [6] = '{3'd0, 3'd5, 3'd1, 3'd2, 3'd4, 3'd3};
      logic [31:0] res[6] = '{32'h1003, 32'h2002, 32'h2002, 32'h2003, 32'h2001, 32'h2000};
      logic [31:0] rd_[6] = '{32'h80000000, 32'hBEEF1234, 32'hBEEF1234, 32'hBEEF1234,
                              32'hBEEF1234, 32'hBEEF1234};
      logic [31:0] exp[6] = '{32'hFFFFFF80, 32'h0000BEEF, 32'hFFFFBEEF, 32'hBEEF1234,
                              32'h00000012, 32'h00000000};
      logic [4:0]  rd [6] = '{5'd5, 5'd7, 5'd7, 5'd8, 5'd9, 5'd11};
      for (int i = 0; i < 6; i++) begin
         drive_mem(1'b1, f3[i], rd[i], res[i], rd_[i]);
         tick();
         exp_instret++;
         n_vec++;
         if (bus.reg_wen_o !== 1'b1 || bus.reg_waddr_o !== rd[i] || bus.reg_wdata_o !== exp[i]
             || bus.instret_o !== exp_instret) begin
            n_err++;
            $display("FAIL load_%0d: got wen=%b waddr=%0d wdata=%h instret=%0d, want 1/%0d/%h/%0d",
                     i, bus.reg_wen_o, bus.reg_waddr_o, bus.reg_wdata_o, bus.instret_o,
                     rd[i], exp[i], exp_instret);
         end
      end
      idle_inputs();
      tick();
      n_vec++;
      if (bus.reg_wen_o !== 1'b0 || bus.instret_o !== exp_instret) begin
         n_err++;
         $display("FAIL load_idle: got wen=%b instret=%0d, want 0/%0d",
                  bus.reg_wen_o, bus.instret_o, exp_instret);
      end
   endtask

   task automatic test_rd_zero();
      drive_mem(1'b0, 3'd0, 5'd0, 32'h55, 32'h0);
      tick();
      exp_instret++;
      n_vec++;
      if (bus.reg_wen_o !== 1'b0 || bus.instret_o !== exp_instret) begin
         n_err++;
         $display("FAIL rd_zero: got wen=%b instret=%0d, want 0/%0d",
                  bus.reg_wen_o, bus.instret_o, exp_instret);
      end
      drive_mem(1'b0, 3'd0, 5'd12, 32'h77, 32'h0);
      bus.mem_wen_i = 1'b0;
      tick();
      exp_instret++;
      n_vec++;
      if (bus.reg_wen_o !== 1'b0 || bus.instret_o !== exp_instret) begin
         n_err++;
         $display("FAIL wen_zero: got wen=%b instret=%0d, want 0/%0d",
                  bus.reg_wen_o, bus.instret_o, exp_instret);
      end
      idle_inputs();
   endtask

   task automatic test_collision();
      drive_mem(1'b0, 3'd0, 5'd3, 32'h11, 32'h0);
      bus.div_valid_i  = 1'b1;
      bus.div_rd_i     = 5'd4;
      bus.div_result_i = 32'h22;
      tick();
      exp_instret++;
      bus.div_valid_i = 1'b0;
      drive_mem(1'b0, 3'd0, 5'd10, 32'h33, 32'h0);
      n_vec++;
      if (bus.reg_wen_o !== 1'b1 || bus.reg_waddr_o !== 5'd3 || bus.reg_wdata_o !== 32'h11
          || bus.wb_stall_o !== 1'b1 || bus.div_ready_o !== 1'b0) begin
         n_err++;
         $display("FAIL coll_c1: got wen=%b waddr=%0d wdata=%h stall=%b ready=%b, want 1/3/11/1/0",
                  bus.reg_wen_o, bus.reg_waddr_o, bus.reg_wdata_o, bus.wb_stall_o, bus.div_ready_o);
      end
      tick();
      n_vec++;
      if (bus.reg_wen_o !== 1'b1 || bus.reg_waddr_o !== 5'd4 || bus.reg_wdata_o !== 32'h22
          || bus.wb_stall_o !== 1'b0 || bus.div_ready_o !== 1'b1 || bus.instret_o !== exp_instret) begin
         n_err++;
         $display("FAIL coll_c2: got wen=%b waddr=%0d wdata=%h stall=%b ready=%b instret=%0d, want 1/4/22/0/1/%0d",
                  bus.reg_wen_o, bus.reg_waddr_o, bus.reg_wdata_o, bus.wb_stall_o, bus.div_ready_o,
                  bus.instret_o, exp_instret);
      end
      tick();
      exp_instret++;
      idle_inputs();
      n_vec++;
      if (bus.reg_wen_o !== 1'b1 || bus.reg_waddr_o !== 5'd10 || bus.reg_wdata_o !== 32'h33
          || bus.instret_o !== exp_instret) begin
         n_err++;
         $display("FAIL coll_c3: got wen=%b waddr=%0d wdata=%h instret=%0d, want 1/10/33/%0d",
                  bus.reg_wen_o, bus.reg_waddr_o, bus.reg_wdata_o, bus.instret_o, exp_instret);
      end
      tick();
   endtask

   task automatic test_flush_and_div();
      drive_mem(1'b0, 3'd0, 5'd9, 32'h99, 32'h0);
      bus.flush_i = 1'b1;
      tick();
      idle_inputs();
      n_vec++;
      if (bus.reg_wen_o !== 1'b0 || bus.instret_o !== exp_instret) begin
         n_err++;
         $display("FAIL flush: got wen=%b instret=%0d, want 0/%0d",
                  bus.reg_wen_o, bus.instret_o, exp_instret);
      end
      bus.flush_i      = 1'b1;
      bus.div_valid_i  = 1'b1;
      bus.div_rd_i     = 5'd6;
      bus.div_result_i = 32'h66;
      tick();
      idle_inputs();
      n_vec++;
      if (bus.reg_wen_o !== 1'b1 || bus.reg_waddr_o !== 5'd6 || bus.reg_wdata_o !== 32'h66
          || bus.wb_stall_o !== 1'b0 || bus.div_ready_o !== 1'b1 || bus.instret_o !== exp_instret) begin
         n_err++;
         $display("FAIL div_alone: got wen=%b waddr=%0d wdata=%h stall=%b ready=%b instret=%0d, want 1/6/66/0/1/%0d",
                  bus.reg_wen_o, bus.reg_waddr_o, bus.reg_wdata_o, bus.wb_stall_o, bus.div_ready_o,
                  bus.instret_o, exp_instret);
      end
      bus.div_valid_i  = 1'b1;
      bus.div_rd_i     = 5'd0;
      bus.div_result_i = 32'hAB;
      tick();
      idle_inputs();
      n_vec++;
      if (bus.reg_wen_o !== 1'b0 || bus.div_ready_o !== 1'b1) begin
         n_err++;
         $display("FAIL div_rd0: got wen=%b ready=%b, want 0/1", bus.reg_wen_o, bus.div_ready_o);
      end
   endtask

   task automatic test_reset_in_pend();
      drive_mem(1'b0, 3'd0, 5'd13, 32'h1313, 32'h0);
      bus.div_valid_i  = 1'b1;
      bus.div_rd_i     = 5'd14;
      bus.div_result_i = 32'h1414;
      tick();
      idle_inputs();
      n_vec++;
      if (bus.wb_stall_o !== 1'b1) begin
         n_err++;
         $display("FAIL pend_entry: got stall=%b, want 1", bus.wb_stall_o);
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      n_vec++;
      if (bus.reg_wen_o !== 1'b0 || bus.instret_o !== 64'd0 || bus.div_ready_o !== 1'b1
          || bus.wb_stall_o !== 1'b0) begin
         n_err++;
         $display("FAIL pend_reset: got wen=%b instret=%0d ready=%b stall=%b, want 0/0/1/0",
                  bus.reg_wen_o, bus.instret_o, bus.div_ready_o, bus.wb_stall_o);
      end
      tick();
      n_vec++;
      if (bus.reg_wen_o !== 1'b0 || bus.instret_o !== 64'd0) begin
         n_err++;
         $display("FAIL pend_discard: got wen=%b waddr=%0d instret=%0d, want 0/-/0",
                  bus.reg_wen_o, bus.reg_waddr_o, bus.instret_o);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      exp_instret = 64'd0;
      idle_inputs();
      test_reset();
      test_load_format();
      test_rd_zero();
      test_collision();
      test_flush_and_div();
      test_reset_in_pend();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Writeback stage sitting directly upstream of the general-purpose register file, driving its single write port (wen/waddr/wdata).
- Registers the MEM-stage result and formats load data (byte/half extraction, sign/zero extension).
- Merges results from the multi-cycle divider through a valid/ready handshake and a one-entry buffer.
- Keeps the retired-instruction counter.

Parameters:
XLEN, 32, data width of results and register writes
REG_ADDR_W, 5, register index width
INSTRET_W, 64, retired-instruction counter width

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_n_i  input  1  reset, synchronous, active-low
flush_i  input  1  kill the MEM entry presented this cycle
mem_valid_i  input  1  MEM stage presents an instruction
mem_wen_i  input  1  instruction writes rd
mem_rd_i  input  REG_ADDR_W  destination register
mem_result_i  input  XLEN  ALU result; for loads, the byte address (bits [1:0] = offset)
mem_is_load_i  input  1  instruction is a load
mem_funct3_i  input  3  load type: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU
mem_rdata_i  input  XLEN  aligned word read from data memory
wb_stall_o  output  1  MEM entry not accepted this cycle; upstream holds
div_valid_i  input  1  divider result available
div_rd_i  input  REG_ADDR_W  divider destination register
div_result_i  input  XLEN  divider result
div_ready_o  output  1  divider result accepted when valid and ready are both high
reg_wen_o  output  1  register-file write enable
reg_waddr_o  output  REG_ADDR_W  register-file write address
reg_wdata_o  output  XLEN  register-file write data
instret_o  output  INSTRET_W  retired-instruction count

Behaviour:
- Reset: clk_i is the single clock. Reset is synchronous on rst_n_i low. It clears:
  - reg_wen_o, reg_waddr_o, reg_wdata_o and instret_o to 0;
  - the divider buffer valid bit;
  - the FSM, which returns to IDLE.
  With the FSM in IDLE after reset, wb_stall_o=0 and div_ready_o=1.
- Write outputs are registered. Data captured at edge N appears on reg_* during cycle N+1 and holds for exactly one cycle. reg_wen_o drops to 0 on the next cycle unless a new write is captured.
- Capture condition: mem_cap = mem_valid_i & ~flush_i & (state==IDLE).
  - On mem_cap, reg_wen_o <= mem_wen_i & (mem_rd_i!=0).
  - A valid entry with rd=0 or wen=0 retires with no write.
- Load formatting (combinational, before the register). Offset off = mem_result_i[1:0].
  - LB/LBU: byte off, sign- or zero-extended.
  - LH/LHU: half selected by off[1], sign- or zero-extended; off[0] is ignored.
  - LW: full word; off is ignored.
  - funct3 3, 6 or 7: data 0, write still performed.
  - Non-load: data = mem_result_i.
- instret_o increments by 1 on every mem_cap, whether or not it writes. It wraps modulo 2^INSTRET_W. Divider writes do not increment it.
- FSM states: IDLE, PEND.
  - IDLE:
    - div_ready_o=1 and wb_stall_o=0.
    - Divider accepted alone (no mem_cap): written next cycle, state stays IDLE.
    - Divider accepted together with mem_cap: the MEM write goes out next cycle and the divider result is stored in the buffer. Next state is PEND.
  - PEND:
    - div_ready_o=0 and wb_stall_o=1.
    - No MEM capture (including flush_i ignored for the buffer); no instret increment.
    - At the next edge the buffer is written to the reg_* outputs, the buffer clears, and next state is IDLE.
  - PEND therefore always lasts exactly one cycle; there is no starvation.
- Divider write with rd=0: reg_wen_o=0; the handshake still completes.
- flush_i has no effect on divider results or the buffer.
- Reset in PEND: the buffered result is discarded and the outputs clear. The divider is responsible for not re-issuing it.
- wb_stall_o and div_ready_o are decoded from the state register only (no combinational path from inputs).

Test Plan:
- LB, result 0x1003, rdata 0x80000000, rd=5, wen=1 → next cycle reg_wen_o=1, waddr=5, wdata=0xFFFFFF80; then wen=0; instret 0→1.
- LHU, result 0x2002, rdata 0xBEEF1234, rd=7 → wdata 0x0000BEEF. Same case with LH → 0xFFFFBEEF.
- ALU write with rd=0, result 0x55 → reg_wen_o stays 0; instret increments.
- MEM ALU rd=3 data 0x11 and div rd=4 data 0x22 valid in the same cycle:
  - C+1: write x3=0x11, wb_stall_o=1, div_ready_o=0; a MEM entry held during C+1 is not captured.
  - C+2: write x4=0x22, stall=0, ready=1.
  - The held MEM entry is captured at the C+2 edge and written at C+3.
- flush_i=1 with mem_valid_i=1, wen=1, rd=9 → no write, instret unchanged. Divider alone with rd=6 → written next cycle, state stays IDLE.
- Reset asserted while in PEND → next cycle reg_wen_o=0, instret=0, div_ready_o=1, wb_stall_o=0; the buffered result is never written.
